// File: rtl/pipe_pkg.sv
// Shared types for the pipeline boundary registers: occupancy type, default
// boundary widths and the payload layouts packed by each stage.
package pipe_pkg;

  typedef logic [1:0] occ_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic [31:0] alu_out;
    logic [31:0] write_data;
    logic [4:0]  write_reg;
  } exmem_payload_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] read_data;
    logic [31:0] alu_out;
    logic [4:0]  write_reg;
  } memwb_payload_t;

  localparam int EXMEM_W = $bits(exmem_payload_t);
  localparam int MEMWB_W = $bits(memwb_payload_t);

  function automatic occ_t occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+payload holding register; load has priority over clear, and clear
// only drops the valid bit so the payload keeps its last written value.
module pipe_slot #(
  parameter int WIDTH = 72
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;

  // valid flag and payload register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= 1'b0;
      data_r  <= {WIDTH{1'b0}};
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= d;
    end else if (clear) begin
      valid_r <= 1'b0;
    end
  end

  assign valid = valid_r;
  assign q     = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline boundary register with optional skid slot, synchronous
// flush, bubble zeroing, occupancy and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH       = 72,
  parameter int SKID        = 1,
  parameter int BUBBLE_ZERO = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output occ_t             occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam bit              SKID_EN = (SKID != 32'sd0);
  localparam bit              BZ_EN   = (BUBBLE_ZERO != 32'sd0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             in_fire_s;
  logic             out_fire_s;
  logic             main_valid_s;
  logic [WIDTH-1:0] main_data_s;
  logic             skid_valid_s;
  logic [WIDTH-1:0] skid_data_s;
  logic             main_load_s;
  logic             main_clr_s;
  logic [WIDTH-1:0] main_d_s;
  logic             skid_load_s;
  logic             skid_clr_s;
  logic [CNT_W-1:0] stall_cnt_r;

  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = main_valid_s & out_ready;

  pipe_slot #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load_s),
    .clear (main_clr_s),
    .d     (main_d_s),
    .valid (main_valid_s),
    .q     (main_data_s)
  );

  // With a skid slot in_ready is a pure flop output; without it, it looks through to out_ready.
  generate
    if (SKID_EN) begin : g_skid
      pipe_slot #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load_s),
        .clear (skid_clr_s),
        .d     (in_data),
        .valid (skid_valid_s),
        .q     (skid_data_s)
      );
      assign in_ready = ~skid_valid_s;
    end else begin : g_noskid
      assign skid_valid_s = 1'b0;
      assign skid_data_s  = {WIDTH{1'b0}};
      assign in_ready     = ~main_valid_s | out_ready;
    end
  endgenerate

  // slot load/clear decisions, priority top-down; the skid entry always refills main first
  always_comb begin
    main_load_s = 1'b0;
    main_clr_s  = 1'b0;
    main_d_s    = in_data;
    skid_load_s = 1'b0;
    skid_clr_s  = 1'b0;
    if (flush) begin
      main_clr_s = 1'b1;
      skid_clr_s = 1'b1;
    end else if (skid_valid_s && out_fire_s) begin
      main_load_s = 1'b1;
      main_d_s    = skid_data_s;
      skid_clr_s  = 1'b1;
    end else if (in_fire_s && (!main_valid_s || out_fire_s)) begin
      main_load_s = 1'b1;
    end else if (in_fire_s && SKID_EN) begin
      skid_load_s = 1'b1;
    end else if (out_fire_s) begin
      main_clr_s = 1'b1;
    end else begin
      main_load_s = 1'b0;
    end
  end

  // stall-cycle counter, saturating, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (main_valid_s && !out_ready && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end
  end

  // bubble payload is zeroed so write-enable controls are inert
  always_comb begin
    if (main_valid_s || !BZ_EN) begin
      out_data = main_data_s;
    end else begin
      out_data = {WIDTH{1'b0}};
    end
  end

  assign out_valid = main_valid_s;
  assign occupancy = occ_count(main_valid_s, skid_valid_s);
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid mode, a small saturating counter
// instance and the single-slot legacy mode with bubble zeroing disabled.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // main instance: SKID=1, BUBBLE_ZERO=1
  logic       flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] occupancy;
  logic [15:0] stall_cnt;

  // saturation instance: CNT_W=4
  logic       s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic [7:0] s_in_data = 8'h00;
  logic       s_in_ready, s_out_valid;
  logic [7:0] s_out_data;
  logic [1:0] s_occupancy;
  logic [3:0] s_stall_cnt;

  // legacy instance: SKID=0, BUBBLE_ZERO=0
  logic       l_flush = 1'b0, l_in_valid = 1'b0, l_out_ready = 1'b0;
  logic [7:0] l_in_data = 8'h00;
  logic       l_in_ready, l_out_valid;
  logic [7:0] l_out_data;
  logic [1:0] l_occupancy;
  logic [15:0] l_stall_cnt;

  pipe_stage_reg #(.WIDTH(8), .SKID(1), .BUBBLE_ZERO(1), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt));

  pipe_stage_reg #(.WIDTH(8), .SKID(1), .BUBBLE_ZERO(1), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt));

  pipe_stage_reg #(.WIDTH(8), .SKID(0), .BUBBLE_ZERO(0), .CNT_W(16)) u_leg (
    .clk(clk), .reset(reset), .flush(l_flush), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_data(l_in_data), .out_valid(l_out_valid), .out_ready(l_out_ready), .out_data(l_out_data),
    .occupancy(l_occupancy), .stall_cnt(l_stall_cnt));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic v, input logic [7:0] d,
                          input logic [1:0] occ, input logic rdy);
    check_eq({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    check_eq({tag, ".out_data"},  {24'd0, out_data},  {24'd0, d});
    check_eq({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, occ});
    check_eq({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, rdy});
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    chk_main("rst0", 1'b0, 8'h00, 2'd0, 1'b1);
    check_eq("rst0.stall", {16'd0, stall_cnt}, 32'd0);
    check_eq("rst0.leg_rdy", {31'd0, l_in_ready}, 32'd1);
    tick(); tick();
    reset = 1'b1;

    // streaming with out_ready held high
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    tick(); chk_main("s11", 1'b1, 8'h11, 2'd1, 1'b1);
    in_data = 8'h22;
    tick(); chk_main("s22", 1'b1, 8'h22, 2'd1, 1'b1);
    in_data = 8'h33;
    tick(); chk_main("s33", 1'b1, 8'h33, 2'd1, 1'b1);
    in_valid = 1'b0;
    tick(); chk_main("sbub", 1'b0, 8'h00, 2'd0, 1'b1);
    check_eq("s.stall", {16'd0, stall_cnt}, 32'd0);

    // backpressure fills the skid slot
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA1;
    tick(); chk_main("bpA1", 1'b1, 8'hA1, 2'd1, 1'b1);
    check_eq("bpA1.stall", {16'd0, stall_cnt}, 32'd0);
    in_data = 8'hA2;
    tick(); chk_main("bpA2", 1'b1, 8'hA1, 2'd2, 1'b0);
    check_eq("bpA2.stall", {16'd0, stall_cnt}, 32'd1);
    in_valid = 1'b0; in_data = 8'hEE;
    tick(); chk_main("bphold", 1'b1, 8'hA1, 2'd2, 1'b0);
    check_eq("bphold.stall", {16'd0, stall_cnt}, 32'd2);
    out_ready = 1'b1;
    tick(); chk_main("drA2", 1'b1, 8'hA2, 2'd1, 1'b1);
    tick(); chk_main("drEmpty", 1'b0, 8'h00, 2'd0, 1'b1);
    check_eq("dr.stall", {16'd0, stall_cnt}, 32'd2);

    // flush at occupancy 2 while downstream accepts
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hB1;
    tick(); in_data = 8'hB2;
    tick(); chk_main("flB", 1'b1, 8'hB1, 2'd2, 1'b0);
    check_eq("flB.stall", {16'd0, stall_cnt}, 32'd3);
    flush = 1'b1; out_ready = 1'b1; in_data = 8'hB3;
    tick(); chk_main("fl2", 1'b0, 8'h00, 2'd0, 1'b1);
    flush = 1'b0; in_valid = 1'b0;
    tick(); chk_main("fl2post", 1'b0, 8'h00, 2'd0, 1'b1);

    // flush with same-cycle in_fire and out_fire drops the input entry
    in_valid = 1'b1; in_data = 8'hC1;
    tick(); chk_main("flC1", 1'b1, 8'hC1, 2'd1, 1'b1);
    flush = 1'b1; in_data = 8'hC2;
    tick(); chk_main("flC2", 1'b0, 8'h00, 2'd0, 1'b1);
    flush = 1'b0; in_valid = 1'b0;
    tick(); chk_main("flC2post", 1'b0, 8'h00, 2'd0, 1'b1);
    check_eq("flC.stall", {16'd0, stall_cnt}, 32'd3);

    // a stalled flush cycle still counts as a stall
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hD1;
    tick(); flush = 1'b1; in_valid = 1'b0;
    tick(); flush = 1'b0;
    check_eq("flD.stall", {16'd0, stall_cnt}, 32'd4);
    check_eq("flD.occ", {30'd0, occupancy}, 32'd0);

    // saturation on a 4-bit counter
    s_in_valid = 1'b1; s_in_data = 8'h5A;
    tick(); s_in_valid = 1'b0;
    check_eq("sat0", {28'd0, s_stall_cnt}, 32'd0);
    for (int i = 0; i < 14; i++) tick();
    check_eq("sat14", {28'd0, s_stall_cnt}, 32'd14);
    tick();
    check_eq("sat15", {28'd0, s_stall_cnt}, 32'd15);
    for (int i = 0; i < 5; i++) tick();
    check_eq("sat20", {28'd0, s_stall_cnt}, 32'd15);
    check_eq("sat.data", {24'd0, s_out_data}, 32'h5A);

    // legacy single slot: in_valid held, out_ready 1,0,0,1
    l_in_valid = 1'b1; l_in_data = 8'h31; l_out_ready = 1'b1;
    check_eq("leg.rdy0", {31'd0, l_in_ready}, 32'd1);
    tick();
    check_eq("leg.d31", {24'd0, l_out_data}, 32'h31);
    l_out_ready = 1'b0; l_in_data = 8'h32;
    #1 check_eq("leg.rdy1", {31'd0, l_in_ready}, 32'd0);
    tick();
    check_eq("leg.hold1", {24'd0, l_out_data}, 32'h31);
    tick();
    check_eq("leg.hold2", {24'd0, l_out_data}, 32'h31);
    check_eq("leg.stall", {16'd0, l_stall_cnt}, 32'd2);
    l_out_ready = 1'b1;
    #1 check_eq("leg.rdy3", {31'd0, l_in_ready}, 32'd1);
    tick();
    check_eq("leg.d32", {24'd0, l_out_data}, 32'h32);
    check_eq("leg.occ", {30'd0, l_occupancy}, 32'd1);
    l_in_valid = 1'b0;
    tick();
    check_eq("leg.bubv", {31'd0, l_out_valid}, 32'd0);
    check_eq("leg.bubd", {24'd0, l_out_data}, 32'h32);

    // asynchronous reset mid-stream with occupancy 2
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hE1;
    tick(); in_data = 8'hE2;
    tick();
    check_eq("pre.occ", {30'd0, occupancy}, 32'd2);
    check_eq("pre.stall", {16'd0, stall_cnt}, 32'd5);
    #2 reset = 1'b0;
    #1;
    chk_main("rstmid", 1'b0, 8'h00, 2'd0, 1'b1);
    check_eq("rstmid.stall", {16'd0, stall_cnt}, 32'd0);
    #1 reset = 1'b1;
    out_ready = 1'b1; in_data = 8'hF1;
    tick(); chk_main("postrst", 1'b1, 8'hF1, 2'd1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
